// File: rtl/regfile_param.sv
// Parametrised register bank: two combinational read ports, one write port,
// optional zero register and write-to-read bypass, sequential bulk clear.
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 16,
  parameter int AW       = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    WA3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  input  logic             clr,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int            LAST_I  = NREGS - 1;
  localparam logic [AW:0]   NREGS_W = NREGS[AW:0];
  localparam logic [AW-1:0] LAST    = LAST_I[AW-1:0];

  state_t           state, state_nx;
  logic [AW-1:0]    idx, idx_nx;
  logic [WIDTH-1:0] mem [NREGS];
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  function automatic logic zero_addr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          idx_nx   = '0;
        end
      end
      CLEAR: begin
        if (idx == LAST) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // clr in IDLE takes priority over a same-cycle write
  always_comb begin
    wr_ok = we3 && !busy && !clr && in_range(WA3) && !zero_addr(WA3);
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[WA3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    if (!busy && in_range(RA1) && !zero_addr(RA1)) begin
      if ((BYPASS != 0) && wr_ok && (WA3 == RA1)) RD1 = WD3;
      else                                        RD1 = mem[RA1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (!busy && in_range(RA2) && !zero_addr(RA2)) begin
      if ((BYPASS != 0) && wr_ok && (WA3 == RA2)) RD2 = WD3;
      else                                        RD2 = mem[RA2];
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and
// are checked against an array-based model of the register bank.
module tb_regfile_param;

  localparam int NCFG = 3;
  localparam int CN [NCFG] = '{16, 16, 12};
  localparam int CZ [NCFG] = '{1, 0, 1};
  localparam int CB [NCFG] = '{1, 0, 1};

  logic       clk, reset, we3, clr;
  logic [3:0] WA3, RA1, RA2;
  logic [7:0] WD3;
  logic [7:0] rd1_o [NCFG];
  logic [7:0] rd2_o [NCFG];
  logic       busy_o [NCFG];

  int vectors, miscompares;

  // model state: contents and remaining busy cycles per configuration
  logic [7:0] mem_m [NCFG][16];
  int         cnt_m [NCFG];

  regfile_param #(.WIDTH(8), .NREGS(16), .AW(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we3(we3), .WA3(WA3), .WD3(WD3), .RA1(RA1), .RA2(RA2),
    .clr(clr), .RD1(rd1_o[0]), .RD2(rd2_o[0]), .busy(busy_o[0]));
  regfile_param #(.WIDTH(8), .NREGS(16), .AW(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we3(we3), .WA3(WA3), .WD3(WD3), .RA1(RA1), .RA2(RA2),
    .clr(clr), .RD1(rd1_o[1]), .RD2(rd2_o[1]), .busy(busy_o[1]));
  regfile_param #(.WIDTH(8), .NREGS(12), .AW(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .we3(we3), .WA3(WA3), .WD3(WD3), .RA1(RA1), .RA2(RA2),
    .clr(clr), .RD1(rd1_o[2]), .RD2(rd2_o[2]), .busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input int k);
    return we3 && (cnt_m[k] == 0) && !clr && (int'(WA3) < CN[k]) && !(CZ[k] == 1 && WA3 == 4'd0);
  endfunction

  function automatic logic [7:0] exp_rd(input int k, input logic [3:0] ra);
    if (reset || cnt_m[k] > 0) return 8'h00;
    if (int'(ra) >= CN[k]) return 8'h00;
    if (CZ[k] == 1 && ra == 4'd0) return 8'h00;
    if (CB[k] == 1 && legal(k) && WA3 == ra) return WD3;
    return mem_m[k][ra];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      cnt_m[k] = CN[k];
      for (int r = 0; r < 16; r++) mem_m[k][r] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NCFG; k++) begin
      if (reset) cnt_m[k] = CN[k];
      else if (cnt_m[k] > 0) cnt_m[k]--;
      else if (clr) begin
        cnt_m[k] = CN[k];
        for (int r = 0; r < 16; r++) mem_m[k][r] = 8'h00;
      end else if (legal(k)) mem_m[k][WA3] = WD3;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; clr = 1'b0; WA3 = '0; WD3 = '0; RA1 = '0; RA2 = '0;
  endtask

  task automatic test_reset();
    int nb [NCFG];
    idle_inputs();
    reset = 1'b1;
    model_reset();
    tick(); tick();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (busy_o[k] !== 1'b1 || rd1_o[k] !== 8'h00 || rd2_o[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] busy=%b rd1=%h rd2=%h want busy=1 rd=00", k, busy_o[k], rd1_o[k], rd2_o[k]);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < NCFG; k++) nb[k] = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      for (int k = 0; k < NCFG; k++) if (busy_o[k]) nb[k]++;
      tick();
    end
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (nb[k] != CN[k]) begin
        miscompares++;
        $display("FAIL reset_busy_len[%0d] got %0d cycles want %0d", k, nb[k], CN[k]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      RA1 = a[3:0]; RA2 = 4'(15 - a);
      #1;
      for (int k = 0; k < NCFG; k++) begin
        vectors++;
        if (rd1_o[k] !== 8'h00 || rd2_o[k] !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_zero[%0d] addr %0d rd1=%h rd2=%h want 00", k, a, rd1_o[k], rd2_o[k]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we3 = 1'b1; WA3 = 4'd5; WD3 = 8'hA7; RA1 = 4'd5; RA2 = 4'd5;
    #1;
    vectors++;
    if (rd1_o[0] !== 8'hA7 || rd2_o[0] !== 8'hA7) begin
      miscompares++;
      $display("FAIL bypass_on rd1=%h rd2=%h want a7", rd1_o[0], rd2_o[0]);
    end
    vectors++;
    if (rd1_o[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL bypass_off_before rd1=%h want 00", rd1_o[1]);
    end
    tick();
    we3 = 1'b0;
    #1;
    vectors++;
    if (rd1_o[1] !== 8'hA7 || rd2_o[1] !== 8'hA7) begin
      miscompares++;
      $display("FAIL bypass_off_after rd1=%h rd2=%h want a7", rd1_o[1], rd2_o[1]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we3 = 1'b1; WA3 = 4'd0; WD3 = 8'hFF; RA1 = 4'd0;
    #1;
    vectors++;
    if (rd1_o[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL zero_reg_bypass rd1=%h want 00", rd1_o[0]);
    end
    tick();
    we3 = 1'b0;
    #1;
    vectors++;
    if (rd1_o[0] !== 8'h00 || rd1_o[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL zero_reg_hold a=%h c=%h want 00", rd1_o[0], rd1_o[2]);
    end
    vectors++;
    if (rd1_o[1] !== 8'hFF) begin
      miscompares++;
      $display("FAIL zero_reg_off rd1=%h want ff", rd1_o[1]);
    end
  endtask

  task automatic test_clr_priority();
    int nb [NCFG];
    idle_inputs();
    we3 = 1'b1; WA3 = 4'd9; WD3 = 8'h3C;
    tick();
    we3 = 1'b0; RA1 = 4'd9;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (rd1_o[k] !== 8'h3C) begin
        miscompares++;
        $display("FAIL clr_prewrite[%0d] rd1=%h want 3c", k, rd1_o[k]);
      end
    end
    clr = 1'b1; we3 = 1'b1; WA3 = 4'd2; WD3 = 8'h11;
    tick();
    idle_inputs();
    for (int k = 0; k < NCFG; k++) nb[k] = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      for (int k = 0; k < NCFG; k++) if (busy_o[k]) nb[k]++;
      tick();
    end
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (nb[k] != CN[k]) begin
        miscompares++;
        $display("FAIL clr_busy_len[%0d] got %0d cycles want %0d", k, nb[k], CN[k]);
      end
    end
    RA1 = 4'd9; RA2 = 4'd2;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (rd1_o[k] !== 8'h00 || rd2_o[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL clr_result[%0d] r9=%h r2=%h want 00", k, rd1_o[k], rd2_o[k]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int nb [NCFG];
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (busy_o[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL midclr_reset_busy[%0d] got %b want 1", k, busy_o[k]);
      end
    end
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < NCFG; k++) nb[k] = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      for (int k = 0; k < NCFG; k++) if (busy_o[k]) nb[k]++;
      tick();
    end
    for (int k = 0; k < NCFG; k++) begin
      vectors++;
      if (nb[k] != CN[k]) begin
        miscompares++;
        $display("FAIL midclr_busy_len[%0d] got %0d cycles want %0d", k, nb[k], CN[k]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      RA1 = a[3:0];
      #1;
      for (int k = 0; k < NCFG; k++) begin
        vectors++;
        if (rd1_o[k] !== 8'h00) begin
          miscompares++;
          $display("FAIL midclr_zero[%0d] addr %0d got %h want 00", k, a, rd1_o[k]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] v;
    idle_inputs();
    for (int a = 1; a < 12; a++) begin
      v = 8'(a * 3 + 1);
      we3 = 1'b1; WA3 = a[3:0]; WD3 = v;
      tick();
    end
    we3 = 1'b1; WA3 = 4'd13; WD3 = 8'h55; RA1 = 4'd13;
    #1;
    vectors++;
    if (rd1_o[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL oor_bypass rd1=%h want 00", rd1_o[2]);
    end
    tick();
    we3 = 1'b0;
    #1;
    vectors++;
    if (rd1_o[2] !== 8'h00) begin
      miscompares++;
      $display("FAIL oor_read rd1=%h want 00", rd1_o[2]);
    end
    for (int a = 0; a < 12; a++) begin
      v = (a == 0) ? 8'h00 : 8'(a * 3 + 1);
      RA1 = a[3:0];
      #1;
      vectors++;
      if (rd1_o[2] !== v) begin
        miscompares++;
        $display("FAIL oor_unchanged addr %0d got %h want %h", a, rd1_o[2], v);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e1, e2;
    logic       eb;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      we3 = ($urandom_range(0, 3) != 0);
      WA3 = 4'($urandom_range(0, 15));
      WD3 = 8'($urandom);
      RA1 = ($urandom_range(0, 3) == 0) ? WA3 : 4'($urandom_range(0, 15));
      RA2 = ($urandom_range(0, 3) == 0) ? RA1 : 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 59) == 0);
      #1;
      for (int k = 0; k < NCFG; k++) begin
        e1 = exp_rd(k, RA1);
        e2 = exp_rd(k, RA2);
        eb = (cnt_m[k] > 0);
        vectors++;
        if (rd1_o[k] !== e1 || rd2_o[k] !== e2 || busy_o[k] !== eb) begin
          miscompares++;
          $display("FAIL random[%0d] step %0d rd1=%h rd2=%h busy=%b want %h %h %b",
                   k, i, rd1_o[k], rd2_o[k], busy_o[k], e1, e2, eb);
        end
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_clr_priority();
    test_reset_mid_clear();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
